// File: rtl/u111_tack_gen.sv
// u111_tack_gen: local-bus cycle terminator that sits behind the U111 cycle/bus-sizing
// state machine.
//
// It decodes the Amiga address space into regions and holds each claimed cycle in WAIT
// until that region is ready. A ROM or chipset-register cycle is ready after a fixed
// count. A chip-RAM cycle is ready when Agnus acknowledges, and a CIA cycle is ready on a
// falling edge of the E clock. The block then returns a one-clock TACKn.
//
// Ports:
//   CLK40        in   40 MHz local bus clock, rising edge only
//   RESETn       in   synchronous active-low reset
//   TSn          in   transfer start, active low, one clock wide
//   RnW          in   1 = read, 0 = write (accepted but not needed to terminate)
//   ADDR         in   A[23:0] of the current bus cycle
//   ADDR_HI_ZERO in   1 when A[31:24] = 0; cycles are only claimed when set
//   ECLK         in   CIA E clock, already synchronised to CLK40
//   CHIP_ACKn    in   Agnus chip-RAM slot acknowledge, active low level
//   TACKn        out  transfer acknowledge, active low, one clock
//   TEAn         out  transfer error acknowledge, active low, one clock
//   PORTSIZE     out  1 = 16-bit port, 0 = 32-bit port, combinational from ADDR
//   REGION       out  region latched at the last accepted TSn (debug / LEDs)
//
// Optional build macro TACK_TIMEOUT_EN enables a watchdog. When the WAIT counter reaches
// TIMEOUT, the cycle is ended with a one-clock TEAn instead of TACKn. Without the macro,
// TEAn is tied high and WAIT lasts until the region is ready.
//
// Timing: TACKn and TEAn are registered from the ACK and ERR states. A cycle that becomes
// ready at sample edge r shows TACKn low for the clock after edge r+1. For ROM, that gives
// a latency of ROM_WAIT+1 clocks from the TSn sample edge.

module u111_tack_gen #(
  parameter int unsigned ROM_WAIT = 4,
  parameter int unsigned REG_WAIT = 6,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        CLK40,
  input  logic        RESETn,
  input  logic        TSn,
  input  logic        RnW,
  input  logic [23:0] ADDR,
  input  logic        ADDR_HI_ZERO,
  input  logic        ECLK,
  input  logic        CHIP_ACKn,
  output logic        TACKn,
  output logic        TEAn,
  output logic        PORTSIZE,
  output logic [2:0]  REGION
);

  // Region codes as seen on REGION.
  localparam logic [2:0] RgnNone = 3'd0;
  localparam logic [2:0] RgnChip = 3'd1;
  localparam logic [2:0] RgnCia  = 3'd2;
  localparam logic [2:0] RgnRegs = 3'd3;
  localparam logic [2:0] RgnRom  = 3'd4;

  // Cycle states.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;
`ifdef TACK_TIMEOUT_EN
  localparam logic [1:0] StErr  = 2'd3;
`endif

  // Exit counts for the fixed-latency regions.
  localparam logic [7:0] RomLast = 8'(ROM_WAIT - 1);
  localparam logic [7:0] RegLast = 8'(REG_WAIT - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] region_q, region_d;
  logic       eclk_q;
  logic       tack_n_q;
  logic       tea_n_q;

  logic [2:0] rgn_dec;
  logic       eclk_fall;
  logic       exit_ok;
  logic [7:0] timeout_cnt;

  assign timeout_cnt = 8'(TIMEOUT);

  // ---------------------------------------------------------------------------------------
  // Address decode. The ranges are disjoint, so the order of the tests is irrelevant.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    rgn_dec = RgnNone;
    if (ADDR_HI_ZERO) begin
      if (ADDR[23:21] == 3'b000) begin
        rgn_dec = RgnChip;               // $000000-$1FFFFF
      end else if (ADDR[23:16] == 8'hBF) begin
        rgn_dec = RgnCia;                // $BFxxxx
      end else if (ADDR[23:12] == 12'hDFF) begin
        rgn_dec = RgnRegs;               // $DFFxxx
      end else if (ADDR[23:19] == 5'b11111) begin
        rgn_dec = RgnRom;                // $F80000-$FFFFFF
      end
    end
  end

  // Every claimed region is a 16-bit port; unclaimed space belongs to 32-bit agents.
  assign PORTSIZE = (rgn_dec != RgnNone);

  // ---------------------------------------------------------------------------------------
  // WAIT exit condition for the region latched at TSn.
  // ---------------------------------------------------------------------------------------
  assign eclk_fall = eclk_q & ~ECLK;

  always_comb begin
    exit_ok = 1'b0;
    unique case (region_q)
      RgnRom:  exit_ok = (cnt_q == RomLast);
      RgnRegs: exit_ok = (cnt_q == RegLast);
      RgnChip: exit_ok = ~CHIP_ACKn;
      // The counter floor keeps an E-clock edge that lands right after TSn from ending
      // the cycle before the CIA has seen the address.
      RgnCia:  exit_ok = eclk_fall && (cnt_q >= 8'd2);
      default: exit_ok = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    region_d = region_q;
    unique case (state_q)
      StIdle: begin
        if (!TSn) begin
          // REGION also records unclaimed cycles (as NONE) so the debug view stays honest.
          region_d = rgn_dec;
          cnt_d    = 8'd0;
          if (rgn_dec != RgnNone) begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (exit_ok) begin
          state_d = StAck;
`ifdef TACK_TIMEOUT_EN
        end else if (cnt_q == timeout_cnt) begin
          // A region that becomes ready in the same clock still wins (checked first).
          state_d = StErr;
`endif
        end
      end
      StAck: begin
        state_d = StIdle;
      end
`ifdef TACK_TIMEOUT_EN
      StErr: begin
        state_d = StIdle;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      region_q <= RgnNone;
      eclk_q   <= 1'b0;
      tack_n_q <= 1'b1;
      tea_n_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      region_q <= region_d;
      eclk_q   <= ECLK;
      tack_n_q <= (state_q != StAck);
`ifdef TACK_TIMEOUT_EN
      tea_n_q  <= (state_q != StErr);
`else
      tea_n_q  <= 1'b1;
`endif
    end
  end

  assign TACKn  = tack_n_q;
  assign REGION = region_q;

`ifdef TACK_TIMEOUT_EN
  assign TEAn = tea_n_q;
`else
  // With no watchdog there is no error path, so the register is not driven out.
  assign TEAn = 1'b1;
`endif

  // The cycle is terminated without regard to direction or the low address bits.
  logic unused_inputs;
  assign unused_inputs = ^{RnW, ADDR[11:0], timeout_cnt, tea_n_q};

  // ---------------------------------------------------------------------------------------
  // Simulation-only sanity checks
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge CLK40) begin
    if (RESETn) begin
      assert (TACKn || TEAn);
      assert (!(state_q == StWait && region_q == RgnNone));
    end
  end

endmodule
